// File: rtl/mips32_pkg.sv
// mips32_pkg -- definitions shared by the decode and writeback stages.
//
// Contents:
//   OP_*        opcode constants (full 6-bit op field, ir[31:26])
//   ALU_RR/IMM  op[5:3] prefixes of the ALU opcode classes
//   wb_state_e  writeback-stage FSM state type
//   is_alu_class  helper: op[5:3] names one of the ALU classes
package mips32_pkg;

  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_BEQZ  = 6'b001101;
  localparam logic [5:0] OP_BNEQZ = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam logic [2:0] ALU_RR  = 3'b000;
  localparam logic [2:0] ALU_IMM = 3'b010;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

  function automatic logic is_alu_class(input logic [2:0] cls);
    return (cls == ALU_RR) || (cls == ALU_IMM);
  endfunction

endpackage

// File: rtl/wb_classify.sv
// wb_classify -- combinational opcode classifier for the writeback stage.
//
// Ports:
//   i_op          in   6  opcode field ir[31:26]
//   o_writes_reg  out  1  op writes a destination register (ALU or LW)
//   o_use_lmd     out  1  writeback data comes from load data (LW)
//   o_is_halt     out  1  op is HLT
module wb_classify
  import mips32_pkg::*;
(
  input  logic [5:0] i_op,
  output logic       o_writes_reg,
  output logic       o_use_lmd,
  output logic       o_is_halt
);

  always_comb begin
    o_use_lmd    = (i_op == OP_LW);
    o_writes_reg = is_alu_class(i_op[5:3]) || (i_op == OP_LW);
    o_is_halt    = (i_op == OP_HLT);
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage -- MIPS32 writeback stage with halt FSM and retire counter.
//
// Accepts one instruction per cycle from MEM while running, registers the
// writeback triple (LMD, rd_w, we) with one cycle of latency, and freezes
// after retiring HLT until reset. Non-writing ops and writes to R0 are
// turned into bubbles (all zero) so the decode bank's unconditional write
// lands harmlessly in R0.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   MEM presents an instruction
//   in_ready   out  1   stage accepts this cycle (RUN only)
//   ir_mem     in   32  instruction word, op=[31:26] rd=[25:21]
//   alu_out    in   32  ALU result
//   lmd_mem    in   32  load data
//   LMD        out  32  registered writeback data
//   rd_w       out  5   registered destination register
//   we         out  1   registered real-write flag
//   halted     out  1   HLT retired, stage frozen
//   retired    out  32  count of accepted instructions (wraps)
//
// Build option WB_BYPASS_EN adds combinational forwarding outputs
// fwd_valid/fwd_rd/fwd_data describing the write the current acceptance
// will perform.
module wb_stage
  import mips32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ir_mem,
  input  logic [31:0] alu_out,
  input  logic [31:0] lmd_mem,
  output logic [31:0] LMD,
  output logic [4:0]  rd_w,
  output logic        we,
  output logic        halted,
  output logic [31:0] retired
`ifdef WB_BYPASS_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  wb_state_e   r_state;
  wb_state_e   w_state_nxt;

  logic [31:0] r_lmd;
  logic [4:0]  r_rd_w;
  logic        r_we;
  logic [31:0] r_retired;

  logic [5:0]  w_op;
  logic [4:0]  w_rd;
  logic        w_accept;
  logic        w_writes_reg;
  logic        w_use_lmd;
  logic        w_is_halt;
  logic        w_wr_en;
  logic [31:0] w_wb_data;
  logic [4:0]  w_wb_rd;
  logic        w_unused_ir;

  assign w_op        = ir_mem[31:26];
  assign w_rd        = ir_mem[25:21];
  assign w_unused_ir = ^ir_mem[20:0];

  wb_classify u_classify (
    .i_op         (w_op),
    .o_writes_reg (w_writes_reg),
    .o_use_lmd    (w_use_lmd),
    .o_is_halt    (w_is_halt)
  );

  // ---------------------------------------------------------------------
  // FSM: RUN accepts work; HALTED ignores in_valid until reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ST_RUN: begin
        in_ready = 1'b1;
        if (in_valid && w_is_halt) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        in_ready    = 1'b0;
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_accept = in_valid && in_ready;

  // A write to R0 is demoted to a bubble, so the decode bank only ever
  // sees we=1 paired with a nonzero destination.
  assign w_wr_en   = w_accept && w_writes_reg && (w_rd != 5'd0);
  assign w_wb_rd   = w_wr_en ? w_rd : 5'd0;
  assign w_wb_data = w_wr_en ? (w_use_lmd ? lmd_mem : alu_out) : 32'd0;

  // ---------------------------------------------------------------------
  // Writeback register and retire counter.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lmd  <= 32'd0;
      r_rd_w <= 5'd0;
      r_we   <= 1'b0;
    end else begin
      r_lmd  <= w_wb_data;
      r_rd_w <= w_wb_rd;
      r_we   <= w_wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= 32'd0;
    end else if (w_accept) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign LMD     = r_lmd;
  assign rd_w    = r_rd_w;
  assign we      = r_we;
  assign retired = r_retired;
  assign halted  = (r_state == ST_HALTED);

`ifdef WB_BYPASS_EN
  assign fwd_valid = w_wr_en;
  assign fwd_rd    = w_wb_rd;
  assign fwd_data  = w_wb_data;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: MEM stage presents an instruction.
REQ-004 SHALL have port in_ready, output, 1 bit: stage accepts this cycle.
REQ-005 SHALL have port ir_mem, input, 32 bits: instruction word; op=[31:26], rd=[25:21].
REQ-006 SHALL have port alu_out, input, 32 bits: ALU result from MEM stage.
REQ-007 SHALL have port lmd_mem, input, 32 bits: load data from data memory.
REQ-008 SHALL have port LMD, output, 32 bits: writeback data to the decode register bank.
REQ-009 SHALL have port rd_w, output, 5 bits: writeback destination register.
REQ-010 SHALL have port we, output, 1 bit: a real register write is in progress.
REQ-011 SHALL have port halted, output, 1 bit: halt retired; pipeline frozen.
REQ-012 SHALL have port retired, output, 32 bits: count of accepted instructions.

Function
REQ-013 SHALL accept an instruction on a rising edge where in_valid && in_ready; accepted values SHALL appear on LMD/rd_w/we one cycle later (latency 1, registered outputs).
REQ-014 SHALL drive in_ready=1 in state RUN and in_ready=0 in state HALTED.
REQ-015 SHALL classify writing ops as: op[5:3]==3'b000 (ALU reg-reg), op[5:3]==3'b010 (ALU imm) -> data=alu_out; op==OP_LW (6'b001000) -> data=lmd_mem.
REQ-016 SHALL treat all other ops (store 6'b001001, branches 6'b001101/6'b001110, halt 6'b111111, undefined) as non-writing.
REQ-017 SHALL, for a writing op with rd!=0, register LMD=data, rd_w=rd, we=1.
REQ-018 SHALL, for a non-writing op, a writing op with rd==0, or a cycle with no acceptance, register LMD=0, rd_w=0, we=0; R0 is the harmless sink for the decode bank's unconditional write.
REQ-019 SHALL implement a two-state FSM: RUN -> HALTED when op==6'b111111 is accepted; HALTED -> HALTED until rst.
REQ-020 SHALL assert halted in the cycle after the halt is accepted; the halt cycle itself SHALL produce rd_w=0, we=0.
REQ-021 SHALL ignore in_valid while HALTED (no acceptance, no count, outputs held at the zero/bubble values).
REQ-022 SHALL increment retired by 1 on every acceptance, halt included; wrap 32'hFFFFFFFF -> 0 without flags.
REQ-023 SHALL exhibit no combinational path from in_valid/ir_mem to LMD, rd_w or we.

Reset
REQ-024 SHALL on rst=1 at a clock edge set state=RUN, LMD=0, rd_w=0, we=0, halted=0, retired=0.
REQ-025 SHALL give rst priority over a simultaneous acceptance; that instruction is dropped and not counted.
REQ-026 SHALL leave HALTED only via rst.

Configuration
REQ-027 SHALL honour macro WB_BYPASS_EN. When defined, the module adds outputs fwd_valid (1), fwd_rd (5) and fwd_data (32), computed combinationally from the current acceptance using the REQ-015..018 rules, for decode-stage forwarding. When undefined, these ports and their logic are absent and the outputs/timing of REQ-013..026 are unchanged.

Structure
REQ-028 SHALL take opcode constants (OP_LW, OP_SW, OP_BEQZ, OP_BNEQZ, OP_HLT), class prefixes (ALU_RR=3'b000, ALU_IMM=3'b010) and the FSM state type from shared package mips32_pkg, which decode also uses.
REQ-029 SHALL place op classification (writes_reg, use_lmd, is_halt) in combinational sub-module wb_classify; FSM, output register and counter stay in wb_stage.

Verification
REQ-030 Scenario: rst, then accept ALU op=6'b000000 rd=5, alu_out=32'h0000_0014 -> next cycle rd_w=5, LMD=32'h14, we=1, retired=1.
REQ-031 Scenario: accept LW rd=7, lmd_mem=32'hDEAD_BEEF, alu_out=32'h100 -> rd_w=7, LMD=32'hDEADBEEF, we=1.
REQ-032 Scenario: accept SW rd=3, then ALU rd=0 alu_out=32'h55 -> both cycles rd_w=0, LMD=0, we=0; retired advances by 2.
REQ-033 Scenario: accept HLT, then hold in_valid=1 with ALU rd=9 for 5 cycles -> halted=1 from the cycle after HLT, in_ready=0, rd_w stays 0, retired frozen; rst returns the stage to RUN with retired=0.
REQ-034 Scenario: force retired=32'hFFFFFFFF, accept one ALU op -> retired=0; and rst asserted together with a valid ALU op -> outputs zero and retired=0.
REQ-035 Scenario (WB_BYPASS_EN defined): accept ALU rd=4 alu_out=32'h99 -> in the same cycle fwd_valid=1, fwd_rd=4, fwd_data=32'h99; registered outputs match one cycle later.
